// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word read at a time from the current PC,
// buffers returned words with their PCs, and flushes stale fetches on redirect.
module fetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              redirect,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t              state;
  logic                discard;
  logic [ADDR_W-1:0]   req_pc;
  logic [DATA_W-1:0]   buf_data [DEPTH];
  logic [ADDR_W-1:0]   buf_pc   [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                req_fire;
  logic                push;
  logic                pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A request is only issued when a slot is free, so its response can always be pushed.
  always_comb begin
    mem_req_valid = rst_n && (state == S_REQ) && !redirect && (count < CNT_W'(DEPTH));
    mem_req_addr  = pc_in;
    req_fire      = mem_req_valid && mem_req_ready;
    pc_advance    = req_fire;
    instr_valid   = rst_n && (count != '0) && !redirect;
    pop           = instr_valid && instr_ready;
    push          = (state == S_WAIT) && mem_rsp_valid && !discard && !redirect;
    instr_data    = buf_data[rd_ptr];
    instr_pc      = buf_pc[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_REQ;
      discard <= 1'b0;
      req_pc  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            req_pc <= pc_in;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A redirect with no response yet leaves one stale word in flight to drop.
          if (mem_rsp_valid) begin
            discard <= 1'b0;
            state   <= S_REQ;
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          buf_data[wr_ptr] <= mem_rsp_data;
          buf_pc[wr_ptr]   <= req_pc;
          wr_ptr           <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule
